s_axi_lite_regmem: RTL and testbench

//  AXI4-Lite slave with a small word-addressed register memory; the downstream target of m_axi_lite.

---
 rtl/s_axi_lite_regmem_pkg.sv | 30 +++
 rtl/s_axi_lite_regmem_if.sv | 38 +++
 rtl/s_axi_lite_regfile.sv | 41 ++++
 rtl/s_axi_lite_regmem.sv | 187 ++++++++++++++++++
 tb/tb_s_axi_lite_regmem.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/s_axi_lite_regmem_pkg.sv
// Shared constants, response codes and channel FSM state types for the
// AXI4-Lite register-memory slave.
package s_axi_lite_regmem_pkg;

    localparam int unsigned DWIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RESP = 2'd1
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RESP = 2'd1
    } rd_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/s_axi_lite_regmem_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface s_axi_lite_regmem_if #(
    parameter int unsigned DWIDTH = 32
);

    logic                  awvalid;
    logic                  awready;
    logic [DWIDTH-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [DWIDTH-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/s_axi_lite_regfile.sv
// DEPTH x DWIDTH flop array: one byte-strobed write port, one registered
// read port, asynchronous clear.
module s_axi_lite_regfile #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IDX_BIT = 4
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                we,
    input  logic [IDX_BIT-1:0]  widx,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [DWIDTH/8-1:0] wstrb,
    input  logic                rd_en,
    input  logic                rd_zero,
    input  logic [IDX_BIT-1:0]  ridx,
    output logic [DWIDTH-1:0]   rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int unsigned k = 0; k < DWIDTH/8; k++) begin
                if (wstrb[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Out-of-range reads load zero so the data bus never leaks a stale word.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[ridx];
        end
    end

endmodule

// File: rtl/s_axi_lite_regmem.sv
// AXI4-Lite slave over a small word-addressed register memory: independent
// write and read channel FSMs, AW/W holding registers and address decode.
module s_axi_lite_regmem #(
    parameter int unsigned       DWIDTH   = s_axi_lite_regmem_pkg::DWIDTH,
    parameter int unsigned       DEPTH    = 16,
    parameter logic [DWIDTH-1:0] BASEADDR = '0
) (
    input  logic                   clk,
    input  logic                   xrst,
    s_axi_lite_regmem_if.slave     bus,
    output logic [DWIDTH-1:0]      probe
);

    import s_axi_lite_regmem_pkg::*;

    localparam int unsigned       STRB_W   = DWIDTH / 8;
    localparam int unsigned       ADDR_LSB = clogb2(STRB_W);
    localparam int unsigned       IDX_BIT  = (clogb2(DEPTH) == 0) ? 1 : clogb2(DEPTH);
    localparam logic [DWIDTH-1:0] SPAN     = DWIDTH'(DEPTH * STRB_W);

    wr_state_e           wr_state, wr_state_n;
    logic                aw_held, aw_held_n;
    logic                w_held, w_held_n;
    logic [DWIDTH-1:0]   aw_addr, aw_addr_n;
    logic [DWIDTH-1:0]   w_data, w_data_n;
    logic [STRB_W-1:0]   w_strb, w_strb_n;
    logic                awready, awready_n;
    logic                wready, wready_n;
    logic                bvalid, bvalid_n;
    logic [1:0]          bresp, bresp_n;

    rd_state_e           rd_state, rd_state_n;
    logic                arready, arready_n;
    logic                rvalid, rvalid_n;
    logic [1:0]          rresp, rresp_n;
    logic [DWIDTH-1:0]   rf_rdata;

    logic [DWIDTH-1:0]   aw_off, ar_off;
    logic                aw_in_range, ar_in_range;
    logic                commit, ar_hs;
    logic                unused_bits;

    // Offsets wrap modulo 2^DWIDTH, so addresses below BASEADDR fall out of range.
    assign aw_off      = aw_addr - BASEADDR;
    assign ar_off      = bus.araddr - BASEADDR;
    assign aw_in_range = aw_off < SPAN;
    assign ar_in_range = ar_off < SPAN;
    assign commit      = (wr_state == W_IDLE) && aw_held && w_held;
    assign ar_hs       = (rd_state == R_IDLE) && bus.arvalid && arready;

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_addr_n  = aw_addr;
        w_data_n   = w_data;
        w_strb_n   = w_strb;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        case (wr_state)
            W_IDLE: begin
                if (commit) begin
                    bvalid_n   = 1'b1;
                    bresp_n    = aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    wr_state_n = W_RESP;
                end else begin
                    if (bus.awvalid && awready) begin
                        aw_held_n = 1'b1;
                        aw_addr_n = bus.awaddr;
                    end
                    if (bus.wvalid && wready) begin
                        w_held_n = 1'b1;
                        w_data_n = bus.wdata;
                        w_strb_n = bus.wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bus.bready) begin
                    bvalid_n   = 1'b0;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
        // Readies are registered: look ahead to next-cycle state and held flags.
        awready_n = (wr_state_n == W_IDLE) && !aw_held_n;
        wready_n  = (wr_state_n == W_IDLE) && !w_held_n;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            aw_addr  <= aw_addr_n;
            w_data   <= w_data_n;
            w_strb   <= w_strb_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rvalid_n   = rvalid;
        rresp_n    = rresp;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_n   = 1'b1;
                    rresp_n    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (rvalid && bus.rready) begin
                    rvalid_n   = 1'b0;
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
        arready_n = (rd_state_n == R_IDLE);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            rresp    <= rresp_n;
        end
    end

    s_axi_lite_regfile #(
        .DWIDTH  (DWIDTH),
        .DEPTH   (DEPTH),
        .IDX_BIT (IDX_BIT)
    ) u_regfile (
        .clk     (clk),
        .xrst    (xrst),
        .we      (commit && aw_in_range),
        .widx    (aw_off[ADDR_LSB +: IDX_BIT]),
        .wdata   (w_data),
        .wstrb   (w_strb),
        .rd_en   (ar_hs),
        .rd_zero (!ar_in_range),
        .ridx    (ar_off[ADDR_LSB +: IDX_BIT]),
        .rdata   (rf_rdata)
    );

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rf_rdata;
    assign bus.rresp   = rresp;

    assign probe = {{(DWIDTH-4){1'b0}}, rd_state, wr_state};

    // Protection bits and sub-word offset bits carry no meaning here.
    assign unused_bits = ^{bus.awprot, bus.arprot, aw_off, ar_off};

endmodule

// File: tb/tb_s_axi_lite_regmem.sv
// Self-checking bench for s_axi_lite_regmem: directed table, hand sequences
// for stalls/ordering/reset, and random traffic against a word-array model.
module tb_s_axi_lite_regmem;

    localparam logic [31:0] BASE = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic [31:0] probe;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] model [16];
    logic [31:0] d;
    logic [1:0]  r;

    always #5 clk = ~clk;

    s_axi_lite_regmem_if #(.DWIDTH(32)) bus ();

    s_axi_lite_regmem #(
        .DWIDTH   (32),
        .DEPTH    (16),
        .BASEADDR (BASE)
    ) dut (
        .clk   (clk),
        .xrst  (xrst),
        .bus   (bus),
        .probe (probe)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] wd,
                                               input logic [3:0] s);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'd64) return 2'b10;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) model[off[5:2]][8*k +: 8] = wd[8*k +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'd64) return {2'b10, 32'h0};
        return {2'b00, model[off[5:2]]};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                             input int unsigned aw_dly, input int unsigned w_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int unsigned c = 0;
        bus.awaddr = a;
        bus.wdata  = wd;
        bus.wstrb  = s;
        while (!(aw_done && w_done) && c < 50) begin
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int unsigned c = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("b_timeout", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                            input int unsigned aw_dly, input int unsigned w_dly,
                            output logic [1:0] resp);
        send_aw_w(a, wd, s, aw_dly, w_dly);
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd, output logic [1:0] resp);
        bit hs = 0;
        int unsigned c = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!hs && c < 50) begin
            hs = bus.arready;
            @(posedge clk); #1;
            c++;
        end
        bus.arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
        bus.rready = 1'b1;
        c = 0;
        while (!bus.rvalid && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("r_timeout", 32'(bus.rvalid), 32'd1);
        rd   = bus.rdata;
        resp = bus.rresp;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0] m;
        logic [1:0]  er;
        logic [31:0] a, wd;
        bit          ok;

        bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 0; bus.arvalid = 0; bus.araddr = '0;
        bus.arprot  = '0; bus.rready = 0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        vecs[0]  = '{1'b1, BASE + 32'h00, 32'h1234_5678, 4'hF, 32'h0,          2'b00};
        vecs[1]  = '{1'b0, BASE + 32'h00, 32'h0,         4'h0, 32'h1234_5678,  2'b00};
        vecs[2]  = '{1'b1, BASE + 32'h01, 32'hCAFE_F00D, 4'h3, 32'h0,          2'b00};
        vecs[3]  = '{1'b0, BASE + 32'h03, 32'h0,         4'h0, 32'h1234_F00D,  2'b00};
        vecs[4]  = '{1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, 4'h8, 32'h0,          2'b00};
        vecs[5]  = '{1'b0, BASE + 32'h3E, 32'h0,         4'h0, 32'hFF00_0000,  2'b00};
        vecs[6]  = '{1'b1, BASE + 32'h40, 32'h0BAD_F00D, 4'hF, 32'h0,          2'b10};
        vecs[7]  = '{1'b0, BASE + 32'h40, 32'h0,         4'h0, 32'h0,          2'b10};
        vecs[8]  = '{1'b0, BASE - 32'h04, 32'h0,         4'h0, 32'h0,          2'b10};
        vecs[9]  = '{1'b1, BASE + 32'h3C, 32'h0000_0055, 4'h1, 32'h0,          2'b00};
        vecs[10] = '{1'b0, BASE + 32'h3C, 32'h0,         4'h0, 32'hFF00_0055,  2'b00};
        vecs[11] = '{1'b0, BASE + 32'h04, 32'h0,         4'h0, 32'h0,          2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_probe",   probe,            32'd0);
        xrst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", 32'(bus.awready), 32'd1);
        check("post_rst_arready", 32'(bus.arready), 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, (i + 1) % 3, r);
                check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
            end else begin
                do_read(vecs[i].addr, d, r);
                check($sformatf("tbl%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end
        end

        // AW+W same cycle: response exactly one edge later
        send_aw_w(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("t1_bvalid_early", 32'(bus.bvalid), 32'd0);
        @(posedge clk); #1;
        check("t1_bvalid", 32'(bus.bvalid), 32'd1);
        check("t1_bresp",  32'(bus.bresp),  32'd0);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("t1_bvalid_clr", 32'(bus.bvalid), 32'd0);
        void'(model_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF));
        do_read(BASE + 32'h8, d, r);
        check("t1_rdata", d, 32'hDEAD_BEEF);
        check("t1_rresp", 32'(r), 32'd0);

        // W three cycles ahead of AW, partial strobes
        do_write(BASE + 32'h4, 32'hAABB_CCDD, 4'hF, 0, 0, r);
        void'(model_write(BASE + 32'h4, 32'hAABB_CCDD, 4'hF));
        bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) ok = 0;
            @(posedge clk); #1;
        end
        check("t2_wready_held", 32'(ok), 32'd1);
        bus.awaddr = BASE + 32'h4; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        wait_b(r);
        check("t2_bresp", 32'(r), 32'd0);
        void'(model_write(BASE + 32'h4, 32'h1122_3344, 4'b0101));
        do_read(BASE + 32'h4, d, r);
        check("t2_rdata", d, 32'hAA22_CC44);

        // Out-of-range write leaves memory untouched
        do_write(BASE + 32'h40, 32'h5A5A_5A5A, 4'hF, 1, 0, r);
        check("t3_bresp", 32'(r), 32'h2);
        for (int i = 0; i < 16; i++) begin
            do_read(BASE + 32'(i * 4), d, r);
            check($sformatf("t3_word%0d", i), d, model[i]);
        end
        do_read(BASE + 32'h40, d, r);
        check("t3_rdata", d, 32'h0);
        check("t3_rresp", 32'(r), 32'h2);

        // bready held low; a read proceeds in parallel
        send_aw_w(BASE + 32'hC, 32'h0F0F_0F0F, 4'hF, 0, 0);
        @(posedge clk); #1;
        check("t4_bvalid", 32'(bus.bvalid), 32'd1);
        check("t4_probe_wresp", probe, 32'h1);
        ok = 1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 ||
                        bus.awready !== 1'b0 || bus.wready !== 1'b0) ok = 0;
                end
            end
            begin
                logic [31:0] pd;
                logic [1:0]  pr;
                do_read(BASE + 32'h8, pd, pr);
                check("t4_par_rdata", pd, 32'hDEAD_BEEF);
                check("t4_par_rresp", 32'(pr), 32'd0);
            end
        join
        check("t4_stall_stable", 32'(ok), 32'd1);
        wait_b(r);
        check("t4_bresp", 32'(r), 32'd0);
        void'(model_write(BASE + 32'hC, 32'h0F0F_0F0F, 4'hF));

        // Burst of 4 writes then 4 reads, slave returns to idle
        for (int i = 0; i < 4; i++) begin
            wd = $urandom;
            do_write(BASE + 32'h20 + 32'(i * 4), wd, 4'hF, 0, 0, r);
            check("t5_bresp", 32'(r), 32'(model_write(BASE + 32'h20 + 32'(i * 4), wd, 4'hF)));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(BASE + 32'h20 + 32'(i * 4), d, r);
            check("t5_rdata", d, model[8 + i]);
        end
        check("t5_probe_idle", probe, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            a = BASE + 32'($urandom_range(0, 19) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 64));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                er = 2'($urandom_range(0, 15));
                do_write(a, wd, 4'({er, 2'($urandom_range(0, 3))}),
                         $urandom_range(0, 3), $urandom_range(0, 3), r);
                check("rnd_bresp", 32'(r),
                      32'(model_write(a, wd, 4'({er, 2'(0)}) | 4'(bus.wstrb[1:0]))));
            end else begin
                m = model_read(a);
                do_read(a, d, r);
                check("rnd_rdata", d, m[31:0]);
                check("rnd_rresp", 32'(r), 32'(m[33:32]));
            end
        end

        // Reset during W_RESP drops the response and clears memory
        send_aw_w(BASE + 32'h20, 32'h7777_7777, 4'hF, 0, 0);
        @(posedge clk); #1;
        check("t6_bvalid_pre", 32'(bus.bvalid), 32'd1);
        #2;
        xrst = 1'b0;
        #1;
        check("t6_bvalid_rst",  32'(bus.bvalid),  32'd0);
        check("t6_awready_rst", 32'(bus.awready), 32'd0);
        @(posedge clk); #1;
        xrst = 1'b1;
        @(posedge clk); #1;
        check("t6_awready_rel", 32'(bus.awready), 32'd1);
        check("t6_wready_rel",  32'(bus.wready),  32'd1);
        check("t6_bvalid_rel",  32'(bus.bvalid),  32'd0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        for (int i = 0; i < 16; i++) begin
            do_read(BASE + 32'(i * 4), d, r);
            check($sformatf("t6_clear%0d", i), d, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
